// File: rtl/oscill_nios_pio_pkg.sv
// Shared constants for the push-button PIO: register map and edge encodings.
// Debounce is built in with OSCILL_PIO_KEY_DEBOUNCE_EN.
package oscill_nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/oscill_nios_pio_debounce.sv
// Single-bit debouncer: output follows din only after it differs for
// DEBOUNCE_CYCLES consecutive cycles.
module oscill_nios_pio_debounce
  import oscill_nios_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable <= din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oscill_nios_pio_key.sv
// Avalon-MM key PIO with edge capture and masked level interrupt.
// Optional per-bit debounce via OSCILL_PIO_KEY_DEBOUNCE_EN.
module oscill_nios_pio_key
  import oscill_nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, stable, prev;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [WIDTH-1:0] edge_cond, clr;
  logic             wr;
  logic             unused_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef OSCILL_PIO_KEY_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    oscill_nios_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (sync2[i]),
      .stable(stable[i])
    );
  end
  assign unused_ok = ^writedata[31:WIDTH];
`else
  assign stable    = sync2;
  assign unused_ok = ^{writedata[31:WIDTH], DEBOUNCE_CYCLES[0]};
`endif

  always_comb begin
    edge_cond = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_cond = ~prev & stable;
      EDGE_FALL: edge_cond = prev & ~stable;
      default:   edge_cond = prev ^ stable;
    endcase
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_EDGE_CAP) ?
               writedata[WIDTH-1:0] : '0;

  // New edges win over a simultaneous write-1-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '1;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      prev     <= stable;
      edge_cap <= (edge_cap & ~clr) | edge_cond;
      if (wr && address == ADDR_IRQ_MASK)
        irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: doc/oscill_nios_pio_key.md
OSCILL_NIOS_PIO_KEY -- requirements
Module: oscill_nios_pio_key

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits (push-buttons, active-low).
REQ-002 Parameter EDGE_TYPE, default 1: edge-capture condition; 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000: stable-input count required before a change is accepted; used only when debounce is compiled in.
REQ-004 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port address, input, 2: Avalon-MM register word address.
REQ-007 Port chipselect, input, 1: Avalon-MM slave select.
REQ-008 Port write_n, input, 1: active-low write strobe.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port in_port, input, WIDTH: asynchronous external key inputs.
REQ-011 Port readdata, output, 32: read data, zero-extended from WIDTH.
REQ-012 Port irq, output, 1: active-high level interrupt.

Function
REQ-013 The register map SHALL be as follows:
  - 0: data, read-only; reads the stable input value.
  - 1: reserved; reads 0, writes ignored.
  - 2: irq_mask, read/write; uses writedata[WIDTH-1:0].
  - 3: edge_capture; reads the capture bits; writing a 1 to a bit clears that bit.
REQ-014 Reads SHALL have zero wait states: readdata is a combinational decode of address, and bits 31:WIDTH are always 0.
REQ-015 A write SHALL occur when chipselect=1 and write_n=0 on a clk edge.
REQ-016 in_port SHALL pass through a two-stage synchronizer (sync1 -> sync2) before any further use.
REQ-017 The stable value SHALL be:
  - sync2, when debounce is compiled out;
  - the debouncer output, when debounce is compiled in (REQ-026).
REQ-018 prev SHALL register the stable value every cycle; the per-bit edge condition SHALL be:
  - falling: prev & ~stable;
  - rising: ~prev & stable;
  - any: prev ^ stable.
REQ-019 An edge-capture bit SHALL set on the clk edge after its edge condition is true, and SHALL remain set until cleared by a write.
REQ-020 Timing without debounce: an in_port change sampled at edge k SHALL be visible at data after edge k+1, set edge_capture at edge k+2, and raise irq combinationally after edge k+2.
REQ-021 irq SHALL equal the OR of (edge_capture & irq_mask).
REQ-022 If a write-1-clear and a new edge hit the same bit in the same cycle, the edge SHALL win and the bit SHALL stay 1.
REQ-023 A clear of bit i SHALL NOT affect any other bit.
REQ-024 An irq_mask change SHALL affect irq on the next cycle, with no loss of captured bits.

Reset
REQ-025 While reset=1, on a clk edge the block SHALL set:
  - sync1, sync2, prev and the stable value to all-ones (keys idle high);
  - irq_mask and edge_capture to 0;
  - all debounce counters to 0;
  consequently irq=0, readdata at address 2 and 3 = 0, and no spurious edge follows reset release; reset mid-debounce SHALL discard the pending change.

Configuration
REQ-026 Macro OSCILL_PIO_KEY_DEBOUNCE_EN SHALL control debouncing:
  - Defined: each bit has a counter that increments while sync2 differs from the stable bit and resets to 0 when they match; when the count reaches DEBOUNCE_CYCLES-1, the stable bit takes sync2 and the counter returns to 0; an input glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the stable value; latency grows by DEBOUNCE_CYCLES cycles.
  - Undefined: there are no counters, stable equals sync2, and REQ-020 timing applies.

Structure
REQ-027 Package oscill_nios_pio_pkg SHALL hold:
  - the register address constants (ADDR_DATA=0, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3);
  - the EDGE_TYPE encodings (EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2).
REQ-028 The per-bit debounce counter SHALL be sub-module oscill_nios_pio_debounce, instantiated WIDTH times only under OSCILL_PIO_KEY_DEBOUNCE_EN.

Verification
REQ-029 Reset then idle: readdata at address 0 = 0x0000000F, at address 2 = 0, at address 3 = 0; irq=0 for 10 cycles.
REQ-030 Falling edge, no debounce: write irq_mask=0x1, then drive in_port 0xF->0xE at edge k; edge_capture reads 0x1 and irq=1 after edge k+2; writing 0x1 to address 3 makes irq=0 the next cycle.
REQ-031 Masked bit: irq_mask=0x1 and a falling edge on bit 2; edge_capture reads 0x4 and irq stays 0; then writing irq_mask=0x4 makes irq=1 the next cycle.
REQ-032 Collision: a write of 0xF to address 3 in the same cycle that bit 1's edge condition is true; edge_capture reads 0x2 afterwards.
REQ-033 Debounce (macro defined, DEBOUNCE_CYCLES=8): a 5-cycle low pulse on bit 0 leaves data=0xF and no capture; a 20-cycle low sets data=0xE and edge_capture=0x1 about 11 cycles after the drop.
REQ-034 Reset mid-debounce: assert reset 4 cycles into a low input; after release with the input still low, data stays 0xF for 8 full cycles before changing.
